cpu_sequencer: RTL and testbench

Cycle-accurate phase controller for the 8-bit multicycle CPU. It replaces delay-driven phase stepping with a clocked state machine that issues one-cycle enable strobes to instruction memory, control unit, register read, ALU, data memory, writeback and PC logic. It owns the program counter, waits on a data-memory acknowledge with timeout, and detects halt. It sits between the top-level CPU and its `instruction_mem`, `control_unit`, `alu` and `data_memory` instances.

---
 rtl/cpu_seq_pkg.sv | 35 +++
 rtl/cpu_sequencer_mem_wait_timer.sv | 25 ++
 rtl/cpu_sequencer.sv | 121 ++++++++++++
 tb/tb_cpu_sequencer.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_seq_pkg.sv
// Shared definitions for the multicycle CPU phase sequencer: state codes,
// default halt encoding and opcode constants also used by control_unit.
package cpu_seq_pkg;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_FETCH   = 4'd1,
    ST_DECODE  = 4'd2,
    ST_REGREAD = 4'd3,
    ST_EXECUTE = 4'd4,
    ST_MEM     = 4'd5,
    ST_WBRES   = 4'd6,
    ST_WB      = 4'd7,
    ST_PCUPD   = 4'd8,
    ST_HALT    = 4'd9
  } state_t;

  localparam logic [7:0] HALT_INSTR_DEFAULT  = 8'h00;
  localparam int         MEM_TIMEOUT_DEFAULT = 15;

  // Opcode constants shared with control_unit.
  localparam logic [7:0] OP_HALT  = 8'h00;
  localparam logic [7:0] OP_LOAD  = 8'h01;
  localparam logic [7:0] OP_STORE = 8'h02;
  localparam logic [7:0] OP_ADD   = 8'h03;
  localparam logic [7:0] OP_SUB   = 8'h04;
  localparam logic [7:0] OP_BEQ   = 8'h05;
  localparam logic [7:0] OP_JMP   = 8'h06;

  // The sequencer is busy in every state except the two resting ones.
  function automatic logic is_busy(input state_t s);
    return !((s == ST_IDLE) || (s == ST_HALT));
  endfunction

endpackage

// File: rtl/cpu_sequencer_mem_wait_timer.sv
// Counts stalled MEM cycles. `expired` is high on the stall cycle that makes
// the count reach MEM_TIMEOUT, so the FSM can leave MEM on that same edge.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       en,
  output logic [7:0] count,
  output logic       expired
);

  localparam logic [7:0] LIMIT_M1 = 8'(MEM_TIMEOUT - 1);

  // Wait counter: cleared outside MEM, advanced on each un-acked MEM cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        count <= 8'd0;
    else if (clear) count <= 8'd0;
    else if (en)    count <= count + 8'd1;
  end

  assign expired = (count == LIMIT_M1);

endmodule

// File: rtl/cpu_sequencer.sv
// Clocked phase controller for the 8-bit multicycle CPU. Issues one-cycle
// phase strobes decoded from the registered state, owns the PC and the
// retired-instruction counter, and halts on HALT_INSTR or an ack timeout.
// Handshake: access_mem_en is a request strobe on the first MEM cycle;
// mem_ack is sampled only while in MEM with a memory enable set, and an
// ack on any MEM cycle (including the first) completes the access.
module cpu_sequencer
  import cpu_seq_pkg::*;
#(
  parameter int         MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT,
  parameter logic [7:0] HALT_INSTR  = HALT_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic [7:0]  instruction,
  input  logic        mem_r_en,
  input  logic        mem_w_en,
  input  logic        jump,
  input  logic [7:0]  alu_result,
  input  logic        mem_ack,
  output logic        fetch_en,
  output logic        decode_en,
  output logic        regread_en,
  output logic        execute_en,
  output logic        access_mem_en,
  output logic        wbres_en,
  output logic        wb_en,
  output logic        pc_en,
  output logic [7:0]  pc,
  output logic [3:0]  state,
  output logic        busy,
  output logic        halted,
  output logic        mem_timeout,
  output logic [15:0] retired
);

  state_t     state_q;
  state_t     state_d;
  logic       mem_req;
  logic       wait_en;
  logic       wait_clear;
  logic       wait_expired;
  logic [7:0] wait_count;

  assign mem_req    = mem_r_en | mem_w_en;
  assign wait_clear = (state_q != ST_MEM);
  assign wait_en    = (state_q == ST_MEM) && mem_req && !mem_ack;

  mem_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_wait (
    .clk     (clk),
    .rst     (reset),
    .clear   (wait_clear),
    .en      (wait_en),
    .count   (wait_count),
    .expired (wait_expired)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic: fixed phase walk with HALT, MEM wait and run gating.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (run) state_d = ST_FETCH;
      ST_FETCH:   state_d = ST_DECODE;
      ST_DECODE:  state_d = (instruction == HALT_INSTR) ? ST_HALT : ST_REGREAD;
      ST_REGREAD: state_d = ST_EXECUTE;
      ST_EXECUTE: state_d = ST_MEM;
      ST_MEM: begin
        if (!mem_req || mem_ack) state_d = ST_WBRES;
        else if (wait_expired)   state_d = ST_HALT;
      end
      ST_WBRES:   state_d = ST_WB;
      ST_WB:      state_d = ST_PCUPD;
      ST_PCUPD:   state_d = run ? ST_FETCH : ST_IDLE;
      ST_HALT:    state_d = ST_HALT;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Phase strobes and status decoded from the registered state.
  always_comb begin
    fetch_en      = (state_q == ST_FETCH);
    decode_en     = (state_q == ST_DECODE);
    regread_en    = (state_q == ST_REGREAD);
    execute_en    = (state_q == ST_EXECUTE);
    // A zero wait count identifies the first MEM cycle.
    access_mem_en = (state_q == ST_MEM) && mem_req && (wait_count == 8'd0);
    wbres_en      = (state_q == ST_WBRES);
    wb_en         = (state_q == ST_WB);
    pc_en         = (state_q == ST_PCUPD);
    busy          = is_busy(state_q);
    halted        = (state_q == ST_HALT);
    state         = state_q;
  end

  // PC and retired counter advance once per completed instruction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc      <= 8'd0;
      retired <= 16'd0;
    end else if (state_q == ST_PCUPD) begin
      pc      <= pc + 8'd1 + (jump ? alu_result : 8'd0);
      retired <= retired + 16'd1;
    end
  end

  // Sticky timeout flag, set on the edge that moves MEM into HALT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                        mem_timeout <= 1'b0;
    else if (wait_en && wait_expired)                 mem_timeout <= 1'b1;
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed-plus-random bench for cpu_sequencer. An instruction-level model
// (PC arithmetic, retired count, expected phase timeline per instruction)
// predicts every strobe, the PC and the state after each instruction.
module tb_cpu_sequencer;

  localparam int TB_TIMEOUT = 4;
  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_FETCH = 4'd1;
  localparam logic [3:0] S_MEM   = 4'd5;
  localparam logic [3:0] S_HALT  = 4'd9;

  logic        clk, reset, run;
  logic [7:0]  instruction, alu_result;
  logic        mem_r_en, mem_w_en, jump, mem_ack;
  logic        fetch_en, decode_en, regread_en, execute_en;
  logic        access_mem_en, wbres_en, wb_en, pc_en;
  logic [7:0]  pc;
  logic [3:0]  state;
  logic        busy, halted, mem_timeout;
  logic [15:0] retired;

  int n_checks = 0;
  int n_errors = 0;
  int model_pc = 0;
  int model_ret = 0;

  cpu_sequencer #(
    .MEM_TIMEOUT (TB_TIMEOUT),
    .HALT_INSTR  (8'h00)
  ) dut (
    .clk (clk), .reset (reset), .run (run), .instruction (instruction),
    .mem_r_en (mem_r_en), .mem_w_en (mem_w_en), .jump (jump),
    .alu_result (alu_result), .mem_ack (mem_ack),
    .fetch_en (fetch_en), .decode_en (decode_en), .regread_en (regread_en),
    .execute_en (execute_en), .access_mem_en (access_mem_en),
    .wbres_en (wbres_en), .wb_en (wb_en), .pc_en (pc_en),
    .pc (pc), .state (state), .busy (busy), .halted (halted),
    .mem_timeout (mem_timeout), .retired (retired)
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] strobes();
    return {busy, fetch_en, decode_en, regread_en, execute_en,
            access_mem_en, wbres_en, wb_en, pc_en};
  endfunction

  task automatic check_reset_vals(input string tag);
    check(tag, {state, pc, retired, strobes(), halted, mem_timeout}, 64'd0);
  endtask

  // Runs one instruction starting at the FETCH-cycle sample point. d is the
  // ack delay after access_mem_en (0..3). Ends at the sample point after PCUPD.
  task automatic run_instr(input logic [7:0] instr, input logic mr, input logic mw,
                           input int d, input logic jmp, input logic [7:0] off,
                           input logic next_run);
    logic       mem;
    int         dm;
    int         last;
    logic [8:0] exp_v;
    mem  = mr | mw;
    dm   = mem ? d : 0;
    last = 7 + dm;
    instruction = instr; mem_r_en = mr; mem_w_en = mw; jump = jmp; alu_result = off;
    for (int c = 0; c <= last; c++) begin
      if (c == 0)            exp_v = 9'b1_1000_0000;
      else if (c == 1)       exp_v = 9'b1_0100_0000;
      else if (c == 2)       exp_v = 9'b1_0010_0000;
      else if (c == 3)       exp_v = 9'b1_0001_0000;
      else if (c <= 4 + dm)  exp_v = (c == 4 && mem) ? 9'b1_0000_1000 : 9'b1_0000_0000;
      else if (c == 5 + dm)  exp_v = 9'b1_0000_0100;
      else if (c == 6 + dm)  exp_v = 9'b1_0000_0010;
      else                   exp_v = 9'b1_0000_0001;
      check($sformatf("strobes_c%0d", c), strobes(), exp_v);
      if (c == 0) check("pc_hold", pc, model_pc);
      // Stray acks outside the MEM wait; none while waiting; ack at 4+d.
      if (mem && c == 4 + d)               mem_ack = 1'b1;
      else if (mem && c >= 4 && c < 4 + d) mem_ack = 1'b0;
      else                                 mem_ack = 1'($urandom_range(0, 1));
      run = (c == last) ? next_run : 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    model_pc  = (model_pc + 1 + (jmp ? int'(off) : 0)) % 256;
    model_ret = (model_ret + 1) % 65536;
    check("pc_next", pc, model_pc);
    check("retired", retired, model_ret);
    check("state_after", state, next_run ? S_FETCH : S_IDLE);
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; instruction = 8'h11; alu_result = 8'h00;
    mem_r_en = 1'b0; mem_w_en = 1'b0; jump = 1'b0; mem_ack = 1'b0;

    // Reset and IDLE hold.
    @(negedge clk);
    check_reset_vals("reset_vals");
    reset = 1'b0;
    @(negedge clk);
    check("idle_hold", state, S_IDLE);
    run = 1'b1;
    @(negedge clk);
    check("first_fetch", state, S_FETCH);

    // Two plain instructions: pc 0 -> 1 -> 2, retired 2.
    run_instr(8'h11, 1'b0, 1'b0, 0, 1'b0, 8'h00, 1'b1);
    run_instr(8'h23, 1'b0, 1'b0, 0, 1'b0, 8'h00, 1'b1);

    // Read with ack 3 cycles after the strobe, then a write with same-cycle ack.
    run_instr(8'h01, 1'b1, 1'b0, 3, 1'b0, 8'h00, 1'b1);
    run_instr(8'h02, 1'b0, 1'b1, 0, 1'b0, 8'h00, 1'b1);

    // Random instruction mix.
    for (int i = 0; i < 16; i++) begin
      run_instr(8'($urandom_range(1, 255)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), $urandom_range(0, 3),
                1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'b1);
    end

    // PC wrap: land on FE, jump +3 -> 02; land on FF, step -> 00.
    run_instr(8'h06, 1'b0, 1'b0, 0, 1'b1, 8'((254 - model_pc - 1 + 512) % 256), 1'b1);
    check("pc_at_fe", pc, 8'hFE);
    run_instr(8'h06, 1'b0, 1'b0, 0, 1'b1, 8'h03, 1'b1);
    check("pc_wrap_jump", pc, 8'h02);
    run_instr(8'h06, 1'b0, 1'b0, 0, 1'b1, 8'((255 - model_pc - 1 + 512) % 256), 1'b1);
    check("pc_at_ff", pc, 8'hFF);
    run_instr(8'h11, 1'b0, 1'b0, 0, 1'b0, 8'h00, 1'b1);
    check("pc_wrap_step", pc, 8'h00);

    // Drop run before PCUPD: park in IDLE, then resume.
    run_instr(8'h11, 1'b1, 1'b0, 2, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle_park", {state, pc, strobes()}, {S_IDLE, 8'(model_pc), 9'd0});
    end
    run = 1'b1;
    @(negedge clk);
    check("resume_fetch", state, S_FETCH);

    // Reset pulsed during a MEM wait.
    instruction = 8'h01; mem_r_en = 1'b1; mem_w_en = 1'b0; mem_ack = 1'b0; jump = 1'b0;
    repeat (5) @(negedge clk);
    check("in_mem_wait", state, S_MEM);
    #2 reset = 1'b1;
    #1 check_reset_vals("reset_mid_mem");
    @(negedge clk);
    reset = 1'b0; run = 1'b1; model_pc = 0; model_ret = 0;
    @(negedge clk);
    check("fetch_after_reset", state, S_FETCH);

    // Reach pc=5, then fetch the halt encoding.
    for (int i = 0; i < 5; i++) run_instr(8'h33, 1'b0, 1'b0, 0, 1'b0, 8'h00, 1'b1);
    check("pc_before_halt", pc, 8'd5);
    instruction = 8'h00; mem_r_en = 1'b0; mem_w_en = 1'b0;
    check("halt_fetch", strobes(), 9'b1_1000_0000);
    @(negedge clk);
    check("halt_decode", strobes(), 9'b1_0100_0000);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check("halt_hold", {state, pc, retired, strobes(), halted, mem_timeout},
            {S_HALT, 8'd5, 16'(model_ret), 9'd0, 1'b1, 1'b0});
      run = ~run;
      @(negedge clk);
    end

    // Ack timeout with MEM_TIMEOUT=4.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; run = 1'b1; model_pc = 0; model_ret = 0;
    @(negedge clk);
    run_instr(8'h44, 1'b0, 1'b0, 0, 1'b0, 8'h00, 1'b1);
    instruction = 8'h02; mem_r_en = 1'b0; mem_w_en = 1'b1; mem_ack = 1'b0;
    for (int c = 0; c < 4 + TB_TIMEOUT; c++) begin
      if (c == 4) check("to_access", strobes(), 9'b1_0000_1000);
      if (c > 4)  check($sformatf("to_wait_c%0d", c), strobes(), 9'b1_0000_0000);
      @(negedge clk);
    end
    check("timeout_halt", {state, pc, retired, busy, halted, mem_timeout},
          {S_HALT, 8'(model_pc), 16'(model_ret), 1'b0, 1'b1, 1'b1});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
